drm_inbuf_ctrl: RTL and testbench

Sequencer for the 16-user de-rate-matching input buffer bank (16 dual-port SRAMs, 2048 x 48 each, one common write address and one common read address).
- Write phase: accepts one user-interleaved LLR word stream, generates the common write address, and raises the per-user write enable.
- Read phase: replays addresses 0..len-1 under downstream flow control, producing all 16 user words per address in parallel.
- Sits between the LLR demapper output and the de-rate-matching core.

---
 rtl/drm_inbuf_pkg.sv | 15 +
 rtl/drm_inbuf_rd_seq.sv | 30 +++
 rtl/drm_inbuf_ctrl.sv | 130 +++++++++++++
 tb/tb_drm_inbuf_ctrl.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/drm_inbuf_pkg.sv
// Shared types and default geometry for the de-rate-matching input buffer sequencer.
package drm_inbuf_pkg;
  localparam int DEF_DATA_W   = 48;
  localparam int DEF_ADDR_W   = 11;
  localparam int DEF_NUM_USER = 16;
  localparam int MAX_LEN      = 2048;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    TURN  = 3'd2,
    READ  = 3'd3,
    DONE  = 3'd4
  } state_e;
endpackage

// File: rtl/drm_inbuf_rd_seq.sv
// Read-phase address generator: one issue per ready cycle, q valid one cycle later.
module drm_inbuf_rd_seq #(
  parameter int ADDR_W = 11
) (
  input  logic              gclk,
  input  logic              grst_n,
  input  logic              en,
  input  logic              rdReady,
  input  logic [ADDR_W-1:0] lastAddr,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              rdValid,
  output logic              lastIssue
);
  logic issue;

  assign issue     = en & rdReady;
  assign lastIssue = issue & (rdAddr == lastAddr);

  // Address parks at 0 whenever the sequencer is not running, so it is 0 in TURN.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      rdAddr  <= '0;
      rdValid <= 1'b0;
    end else begin
      rdValid <= issue;
      if (!en || lastIssue) rdAddr <= '0;
      else if (issue)       rdAddr <= rdAddr + 1'b1;
    end
  end
endmodule

// File: rtl/drm_inbuf_ctrl.sv
// Write/read sequencer for the 16-user input buffer bank.
// Optional overflow monitor enabled by defining DRM_INBUF_OVF_CHECK_EN.
module drm_inbuf_ctrl
  import drm_inbuf_pkg::*;
#(
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int ADDR_W   = DEF_ADDR_W,
  parameter  int NUM_USER = DEF_NUM_USER,
  localparam int UW       = $clog2(NUM_USER)
) (
  input  logic                i_core_clk,
  input  logic                i_rx_rstn,
  input  logic                i_start,
  input  logic [UW:0]         i_num_user,
  input  logic [ADDR_W:0]     i_wr_len,
  input  logic                i_in_valid,
  input  logic [DATA_W-1:0]   i_in_data,
  output logic                o_in_ready,
  output logic [ADDR_W-1:0]   o_wr_addr,
  output logic [DATA_W-1:0]   o_wr_data,
  output logic [NUM_USER-1:0] o_wr_en,
  input  logic                i_rd_ready,
  output logic [ADDR_W-1:0]   o_rd_addr,
  output logic                o_rd_valid,
  output logic                o_busy,
  output logic                o_done,
  output logic                o_cfg_err
`ifdef DRM_INBUF_OVF_CHECK_EN
  ,
  output logic [15:0]         o_ovf_cnt,
  output logic                o_ovf_flag
`endif
);
  localparam logic [UW:0]     MAX_N = (UW+1)'(NUM_USER);
  localparam logic [ADDR_W:0] MAX_L = {1'b1, {ADDR_W{1'b0}}};

  state_e            state;
  logic [UW-1:0]     userCnt, nLast;
  logic [ADDR_W-1:0] addrCnt, lLast;
  logic [UW:0]       numClamp;
  logic [ADDR_W:0]   lenClamp;
  logic              cfgBad, rdLast;

  always_comb begin
    numClamp = (i_num_user > MAX_N) ? MAX_N : i_num_user;
    lenClamp = (i_wr_len > MAX_L) ? MAX_L : i_wr_len;
    cfgBad   = (i_num_user == '0) || (i_wr_len == '0);
  end

  assign o_busy = (state != IDLE);

  drm_inbuf_rd_seq #(.ADDR_W(ADDR_W)) u_rdSeq (
    .gclk      (i_core_clk),
    .grst_n    (i_rx_rstn),
    .en        (state == READ),
    .rdReady   (i_rd_ready),
    .lastAddr  (lLast),
    .rdAddr    (o_rd_addr),
    .rdValid   (o_rd_valid),
    .lastIssue (rdLast)
  );

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      state      <= IDLE;
      userCnt    <= '0;
      addrCnt    <= '0;
      nLast      <= '0;
      lLast      <= '0;
      o_in_ready <= 1'b0;
      o_wr_en    <= '0;
      o_wr_addr  <= '0;
      o_wr_data  <= '0;
      o_done     <= 1'b0;
      o_cfg_err  <= 1'b0;
    end else begin
      o_wr_en   <= '0;
      o_done    <= 1'b0;
      o_cfg_err <= 1'b0;
      unique case (state)
        IDLE: if (i_start) begin
          if (cfgBad) o_cfg_err <= 1'b1;
          else begin
            nLast      <= UW'(numClamp - 1'b1);
            lLast      <= ADDR_W'(lenClamp - 1'b1);
            userCnt    <= '0;
            addrCnt    <= '0;
            o_in_ready <= 1'b1;
            state      <= WRITE;
          end
        end
        WRITE: if (i_in_valid && o_in_ready) begin
          o_wr_en   <= NUM_USER'(1) << userCnt;
          o_wr_addr <= addrCnt;
          o_wr_data <= i_in_data;
          if (userCnt == nLast) begin
            userCnt <= '0;
            // Final beat: ready falls at this edge so nothing further is taken.
            if (addrCnt == lLast) begin
              o_in_ready <= 1'b0;
              state      <= TURN;
            end else addrCnt <= addrCnt + 1'b1;
          end else userCnt <= userCnt + 1'b1;
        end
        TURN: state <= READ;
        READ: if (rdLast) begin
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DRM_INBUF_OVF_CHECK_EN
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      o_ovf_cnt  <= '0;
      o_ovf_flag <= 1'b0;
    end else if (state == IDLE && i_start) begin
      o_ovf_cnt  <= '0;
      o_ovf_flag <= 1'b0;
    end else if (i_in_valid && !o_in_ready && o_busy) begin
      o_ovf_flag <= 1'b1;
      if (o_ovf_cnt != 16'hFFFF) o_ovf_cnt <= o_ovf_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_drm_inbuf_ctrl.sv
// Directed + randomized bench for drm_inbuf_ctrl against a beat-level model.
// Also covers the overflow monitor when DRM_INBUF_OVF_CHECK_EN is defined.
module tb_drm_inbuf_ctrl;
  logic        i_core_clk = 1'b0;
  logic        i_rx_rstn  = 1'b0;
  logic        i_start    = 1'b0;
  logic [4:0]  i_num_user = '0;
  logic [11:0] i_wr_len   = '0;
  logic        i_in_valid = 1'b0;
  logic [47:0] i_in_data  = '0;
  logic        i_rd_ready = 1'b0;
  logic        o_in_ready, o_rd_valid, o_busy, o_done, o_cfg_err;
  logic [10:0] o_wr_addr, o_rd_addr;
  logic [47:0] o_wr_data;
  logic [15:0] o_wr_en;
`ifdef DRM_INBUF_OVF_CHECK_EN
  logic [15:0] o_ovf_cnt;
  logic        o_ovf_flag;
`endif

  drm_inbuf_ctrl dut (
    .i_core_clk (i_core_clk),
    .i_rx_rstn  (i_rx_rstn),
    .i_start    (i_start),
    .i_num_user (i_num_user),
    .i_wr_len   (i_wr_len),
    .i_in_valid (i_in_valid),
    .i_in_data  (i_in_data),
    .o_in_ready (o_in_ready),
    .o_wr_addr  (o_wr_addr),
    .o_wr_data  (o_wr_data),
    .o_wr_en    (o_wr_en),
    .i_rd_ready (i_rd_ready),
    .o_rd_addr  (o_rd_addr),
    .o_rd_valid (o_rd_valid),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_cfg_err  (o_cfg_err)
`ifdef DRM_INBUF_OVF_CHECK_EN
    ,
    .o_ovf_cnt  (o_ovf_cnt),
    .o_ovf_flag (o_ovf_flag)
`endif
  );

  always #5 i_core_clk = ~i_core_clk;

  typedef struct {
    logic [15:0] en;
    logic [10:0] addr;
    logic [47:0] data;
  } wr_t;

  int          vecs = 0, miss = 0;
  wr_t         wrQ[$];
  logic [10:0] rdQ[$];
  logic [47:0] dataQ[$];
  logic [10:0] prevRdAddr = '0;
  int          doneCnt = 0;
  logic        doneVal = 1'b0;

  // Observe writes, read issues (address seen the cycle before each valid) and done.
  always @(negedge i_core_clk) begin
    if (o_wr_en != '0) wrQ.push_back('{o_wr_en, o_wr_addr, o_wr_data});
    if (o_rd_valid) rdQ.push_back(prevRdAddr);
    if (o_done) begin doneCnt++; doneVal = o_rd_valid; end
    prevRdAddr <= o_rd_addr;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [95:0] allOut();
    return {5'd0, o_in_ready, o_wr_addr, o_wr_data, o_wr_en, o_rd_addr,
            o_rd_valid, o_busy, o_done, o_cfg_err};
  endfunction

  task automatic startJob(input int nu, input int len);
    wrQ.delete(); rdQ.delete(); dataQ.delete();
    doneCnt = 0;
    i_rd_ready = 1'b0;
    i_num_user = 5'(nu); i_wr_len = 12'(len); i_start = 1'b1;
    @(posedge i_core_clk); #1;
    i_start = 1'b0;
    chk("start_ready", 96'(o_in_ready), 96'(1));
    chk("start_busy", 96'(o_busy), 96'(1));
`ifdef DRM_INBUF_OVF_CHECK_EN
    chk("ovf_clear", {o_ovf_flag, o_ovf_cnt}, 96'(0));
`endif
  endtask

  // vMode: 0 always valid, 1 alternate, 2 random
  task automatic feed(input int total, input int vMode, input bit full, input bit hold);
    int sent = 0, cyc = 0;
    logic v;
    while (sent < total && cyc < total * 8 + 50) begin
      v = (vMode == 0) ? 1'b1 : (vMode == 1) ? (cyc % 2 == 0) : ($urandom_range(3) != 0);
      i_in_valid = v;
      i_in_data  = {16'($urandom), 32'($urandom)};
      if (v && o_in_ready) begin dataQ.push_back(i_in_data); sent++; end
      @(posedge i_core_clk); #1;
      cyc++;
    end
    if (!hold) i_in_valid = 1'b0;
    chk("beats_sent", 96'(sent), 96'(total));
    if (full) chk("ready_drop", 96'(o_in_ready), 96'(0));
    if (hold) begin
      repeat (2) begin
        @(posedge i_core_clk); #1;
        chk("no_extra_accept", 96'(o_in_ready), 96'(0));
      end
      @(posedge i_core_clk); #1;
      i_in_valid = 1'b0;
`ifdef DRM_INBUF_OVF_CHECK_EN
      chk("ovf_cnt", 96'(o_ovf_cnt), 96'(3));
      chk("ovf_flag", 96'(o_ovf_flag), 96'(1));
`endif
    end
  endtask

  // rMode: 0 always ready, 1 fixed backpressure pattern, 2 random
  task automatic finish(input int n, input int l, input int rMode);
    logic [7:0] pat = 8'b1101_1001;
    int bad = 0;
    for (int k = 0; k < 20 * l + 50; k++) begin
      i_rd_ready = (rMode == 0) ? 1'b1 : (rMode == 1) ? ((k < 8) ? pat[k] : 1'b1)
                                                      : 1'($urandom_range(1));
      @(posedge i_core_clk); #1;
      if (doneCnt > 0) break;
    end
    i_rd_ready = 1'b0;
    chk("done_once", 96'(doneCnt), 96'(1));
    chk("done_with_valid", 96'(doneVal), 96'(1));
    chk("busy_drop", 96'(o_busy), 96'(0));
    chk("wr_count", 96'(wrQ.size()), 96'(n * l));
    for (int j = 0; j < wrQ.size() && j < dataQ.size(); j++)
      if (wrQ[j].en !== 16'(1 << (j % n)) || wrQ[j].addr !== 11'(j / n) || wrQ[j].data !== dataQ[j])
        bad++;
    chk("wr_content", 96'(bad), 96'(0));
    chk("rd_count", 96'(rdQ.size()), 96'(l));
    bad = 0;
    foreach (rdQ[j]) if (rdQ[j] !== 11'(j)) bad++;
    chk("rd_order", 96'(bad), 96'(0));
  endtask

  task automatic job(input int nu, input int len, input int vMode, input int rMode);
    int n = (nu > 16) ? 16 : nu;
    int l = (len > 2048) ? 2048 : len;
    startJob(nu, len);
    feed(n * l, vMode, 1'b1, 1'b0);
    finish(n, l, rMode);
  endtask

  task automatic badCfg(input int nu, input int len);
    wrQ.delete();
    i_num_user = 5'(nu); i_wr_len = 12'(len); i_start = 1'b1;
    @(posedge i_core_clk); #1;
    i_start = 1'b0;
    chk("cfg_err_pulse", 96'(o_cfg_err), 96'(1));
    chk("cfg_err_busy", 96'(o_busy), 96'(0));
    @(posedge i_core_clk); #1;
    chk("cfg_err_single", 96'(o_cfg_err), 96'(0));
    chk("cfg_err_idle", 96'(o_busy), 96'(0));
    chk("cfg_err_nowrite", 96'(wrQ.size()), 96'(0));
  endtask

  initial begin
    #3;
    chk("reset_outputs", allOut(), 96'(0));
    @(posedge i_core_clk); #1;
    i_rx_rstn = 1'b1;
    @(posedge i_core_clk); #1;

    job(16, 4, 0, 0);
    job(3, 2, 1, 0);
    job(2, 5, 2, 1);
    badCfg(0, 4);
    badCfg(3, 0);

    // Reset in the middle of a write phase, then a small clean job.
    startJob(16, 4);
    feed(10, 0, 1'b0, 1'b0);
    #2 i_rx_rstn = 1'b0;
    #1 chk("async_reset", allOut(), 96'(0));
    @(posedge i_core_clk); #1;
    i_rx_rstn = 1'b1;
    @(posedge i_core_clk); #1;
    job(2, 1, 0, 0);

    // Full-depth single user, with valid held through TURN/READ.
    startJob(1, 2048);
    feed(2048, 0, 1'b1, 1'b1);
    finish(1, 2048, 2);
    chk("last_wr_addr", 96'(wrQ[$].addr), 96'(2047));

    job(31, 2, 2, 2);
    job(1, 4095, 0, 0);
    for (int r = 0; r < 4; r++)
      job($urandom_range(16, 1), $urandom_range(6, 1), $urandom_range(2), $urandom_range(2));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
